shift_undo: RTL and testbench
=============================

SHIFT_UNDO -- requirements
Module: shift_undo

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of the shift register.
REQ-002 SHALL have parameter DEPTH, default 8, number of undo-history entries.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load  input  1  load load_data into r and clear history.
REQ-006 SHALL have port load_data  input  WIDTH  value loaded on load.
REQ-007 SHALL have port op_valid  input  1  apply mode to r this cycle.
REQ-008 SHALL have port mode  input  3  forward operation code.
REQ-009 SHALL have port undo  input  1  reverse the most recent recorded operation.
REQ-010 SHALL have port r  output  WIDTH  current register value.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  number of history entries held.
REQ-012 SHALL have ports full and empty, output, 1 each: level==DEPTH and level==0.
REQ-013 SHALL have port err  output  1  one-cycle pulse on a rejected command.

Function
REQ-014 SHALL use the following forward modes:
- 000 shl fill 0
- 001 shl fill 1
- 010 shr fill 0
- 011 shr fill 1
- 100 shl fill 0
- 101 rotate right
- 110 bit reverse
- 111 rotate right
REQ-015 SHALL set the lost bit to the old r[WIDTH-1] for shl modes, the old r[0] for shr modes, and 0 for rotate/reverse modes.
REQ-016 SHALL, on an accepted op_valid, update r to the forward result and push {mode, lost bit} in the same edge; r is visible the next cycle (latency 1).
REQ-017 SHALL, on an accepted undo, pop the top entry and apply its inverse in the same edge:
- shl: shift right, MSB <= lost bit
- shr: shift left, LSB <= lost bit
- rotate right: rotate left
- reverse: reverse
REQ-018 SHALL give priority load > undo > op_valid; a lower-priority command asserted in the same cycle is ignored, with no err.
REQ-019 SHALL, on load, set r=load_data and level=0, regardless of the current history.
REQ-020 SHALL reject op_valid when full: r and history unchanged, err=1 for one cycle.
REQ-021 SHALL reject undo when empty: r unchanged, err=1 for one cycle.
REQ-022 SHALL hold r, level and history when no command is asserted.
REQ-023 SHALL register full, empty and err; full and empty reflect level after the edge.
REQ-024 SHALL guarantee that any accepted op sequence followed by the same number of undos restores r exactly.

Reset
REQ-025 SHALL, on rst high at a rising edge, set r=0, level=0, empty=1, full=0, err=0 and discard all history.
REQ-026 SHALL give rst priority over all commands, including in the middle of any op/undo sequence.

Structure
REQ-027 SHALL take the mode encodings (3'b000..3'b111) and the DEPTH default from shared package shift_pkg.
REQ-028 SHALL implement the history as sub-module shift_stack: a LIFO of DEPTH entries, 4 bits each, with push, pop, clear, top, level, full and empty.
REQ-029 SHALL implement the forward and inverse transforms as combinational functions in shift_undo; no other sub-modules.

Verification
REQ-030 SHALL cover: load 4'b1011, op mode 000 -> r=0110, level=1; undo -> r=1011, level=0.
REQ-031 SHALL cover: load 4'b1001, ops 011, 101, 110 -> r=0110; three undos -> r=1001, empty=1.
REQ-032 SHALL cover: 8 accepted ops -> full=1; 9th op -> err pulse, r unchanged, level=8.
REQ-033 SHALL cover: undo with empty=1 -> err pulse; undo+op_valid same cycle -> only undo applied; load+undo same cycle -> r=load_data, level=0.
REQ-034 SHALL cover: rst asserted after 3 ops -> r=0, level=0, empty=1 next cycle; a following undo gives err.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift register with undo history: mode codes,
// operation classes and the history entry layout.
package shift_pkg;

  localparam int DEPTH_DEFAULT = 8;
  localparam int ENTRY_W       = 4;

  typedef enum logic [2:0] {
    MODE_SHL0     = 3'b000,
    MODE_SHL1     = 3'b001,
    MODE_SHR0     = 3'b010,
    MODE_SHR1     = 3'b011,
    MODE_SHL0_ALT = 3'b100,
    MODE_ROR      = 3'b101,
    MODE_REV      = 3'b110,
    MODE_ROR_ALT  = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    CLS_SHL,
    CLS_SHR,
    CLS_ROR,
    CLS_REV
  } op_class_e;

  typedef struct packed {
    logic [2:0] mode;
    logic       lost;
  } hist_entry_t;

  function automatic op_class_e mode_class(input logic [2:0] m);
    op_class_e cls;
    case (m)
      MODE_SHL0, MODE_SHL1, MODE_SHL0_ALT: cls = CLS_SHL;
      MODE_SHR0, MODE_SHR1:                cls = CLS_SHR;
      MODE_ROR, MODE_ROR_ALT:              cls = CLS_ROR;
      default:                             cls = CLS_REV;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/shift_stack.sv
// LIFO holding the undo history. Push and pop are ignored when full or empty;
// clear drops every entry. full/empty are registered from the next level.
module shift_stack
  import shift_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int LVL_W = $clog2(DEPTH) + 1,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [ENTRY_W-1:0] top,
  output logic [LVL_W-1:0]   level,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [LVL_W-1:0]   level_q, level_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic [LVL_W-1:0]   top_lvl;
  logic [IDX_W-1:0]   wr_idx, rd_idx;

  assign top_lvl = level_q - LVL_W'(1);
  assign wr_idx  = level_q[IDX_W-1:0];
  assign rd_idx  = top_lvl[IDX_W-1:0];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_d   = mem_q;
    level_d = level_q;
    if (clear) begin
      level_d = '0;
    end else if (push && !full_q) begin
      mem_d[wr_idx] = push_data;
      level_d       = level_q + LVL_W'(1);
    end else if (pop && !empty_q) begin
      level_d = top_lvl;
    end
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; level alone decides
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top   = mem_q[rd_idx];
  assign level = level_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/shift_undo.sv
// Shift register with reversible operations: each accepted op records
// {mode, lost bit} so that undo can restore the previous value exactly.
module shift_undo
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     op_valid,
  input  logic [2:0]               mode,
  input  logic                     undo,
  output logic [WIDTH-1:0]         r,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] res;
    for (int i = 0; i < WIDTH; i++) res[i] = v[WIDTH-1-i];
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] fwd_xform(input logic [WIDTH-1:0] v,
                                                 input logic [2:0]       m);
    logic [WIDTH-1:0] res;
    case (mode_class(m))
      CLS_SHL: res = {v[WIDTH-2:0], m == MODE_SHL1};
      CLS_SHR: res = {m == MODE_SHR1, v[WIDTH-1:1]};
      CLS_ROR: res = {v[0], v[WIDTH-1:1]};
      default: res = bit_rev(v);
    endcase
    return res;
  endfunction

  // Rotate and reverse lose nothing, so they record 0.
  function automatic logic lost_bit(input logic [WIDTH-1:0] v,
                                    input logic [2:0]       m);
    logic b;
    case (mode_class(m))
      CLS_SHL: b = v[WIDTH-1];
      CLS_SHR: b = v[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] inv_xform(input logic [WIDTH-1:0] v,
                                                 input hist_entry_t      e);
    logic [WIDTH-1:0] res;
    case (mode_class(e.mode))
      CLS_SHL: res = {e.lost, v[WIDTH-1:1]};
      CLS_SHR: res = {v[WIDTH-2:0], e.lost};
      CLS_ROR: res = {v[WIDTH-2:0], v[WIDTH-1]};
      default: res = bit_rev(v);
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0]   r_q, r_d;
  logic               err_q, err_d;
  logic               st_push, st_pop, st_clear;
  hist_entry_t        push_entry;
  logic [ENTRY_W-1:0] st_top;
  logic [LVL_W-1:0]   st_level;
  logic               st_full, st_empty;

  // Priority is load > undo > op_valid; losers are silently dropped.
  always_comb begin
    r_d        = r_q;
    err_d      = 1'b0;
    st_push    = 1'b0;
    st_pop     = 1'b0;
    st_clear   = 1'b0;
    push_entry = '{mode: mode, lost: lost_bit(r_q, mode)};
    if (load) begin
      r_d      = load_data;
      st_clear = 1'b1;
    end else if (undo) begin
      if (st_empty) begin
        err_d = 1'b1;
      end else begin
        st_pop = 1'b1;
        r_d    = inv_xform(r_q, hist_entry_t'(st_top));
      end
    end else if (op_valid) begin
      if (st_full) begin
        err_d = 1'b1;
      end else begin
        st_push = 1'b1;
        r_d     = fwd_xform(r_q, mode);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      err_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      err_q <= err_d;
    end
  end

  shift_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (st_push),
    .pop       (st_pop),
    .clear     (st_clear),
    .push_data (push_entry),
    .top       (st_top),
    .level     (st_level),
    .full      (st_full),
    .empty     (st_empty)
  );

  assign r     = r_q;
  assign level = st_level;
  assign full  = st_full;
  assign empty = st_empty;
  assign err   = err_q;

endmodule

// File: tb/tb_shift_undo.sv
// Bench for shift_undo: a behavioural model fills a scoreboard each cycle,
// and directed scenarios add fixed expected values.
module tb_shift_undo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  logic             clk = 1'b0;
  logic             rst, load, op_valid, undo;
  logic [WIDTH-1:0] load_data;
  logic [2:0]       mode;
  logic [WIDTH-1:0] r;
  logic [LVL_W-1:0] level;
  logic             full, empty, err;

  shift_undo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .op_valid  (op_valid),
    .mode      (mode),
    .undo      (undo),
    .r         (r),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] r;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             empty;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_r;
  logic [3:0]       m_hist[$];
  int               n_checks = 0;
  int               n_errors = 0;

  function automatic logic [WIDTH-1:0] ref_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] res = '0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) res = res | (MSB >> i);
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] ref_fwd(input logic [WIDTH-1:0] v, input logic [2:0] m);
    case (m)
      3'b000, 3'b100: return v << 1;
      3'b001:         return (v << 1) | WIDTH'(1);
      3'b010:         return v >> 1;
      3'b011:         return (v >> 1) | MSB;
      3'b110:         return ref_rev(v);
      default:        return (v >> 1) | (v << (WIDTH - 1));
    endcase
  endfunction

  function automatic logic ref_lost(input logic [WIDTH-1:0] v, input logic [2:0] m);
    case (m)
      3'b000, 3'b001, 3'b100: return v[WIDTH-1];
      3'b010, 3'b011:         return v[0];
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] ref_inv(input logic [WIDTH-1:0] v, input logic [3:0] e);
    logic [2:0] m = e[3:1];
    logic       b = e[0];
    case (m)
      3'b000, 3'b001, 3'b100: return (v >> 1) | (b ? MSB : '0);
      3'b010, 3'b011:         return (v << 1) | WIDTH'(b);
      3'b110:                 return ref_rev(v);
      default:                return (v << 1) | (v >> (WIDTH - 1));
    endcase
  endfunction

  // Drive one cycle of inputs, predict the outcome, then compare after the edge.
  task automatic step(input string name, input logic i_rst, input logic i_load,
                      input logic [WIDTH-1:0] i_ld, input logic i_op,
                      input logic [2:0] i_mode, input logic i_undo);
    exp_t e;
    exp_t got;
    rst = i_rst; load = i_load; load_data = i_ld;
    op_valid = i_op; mode = i_mode; undo = i_undo;
    e.name = name;
    e.err  = 1'b0;
    if (i_rst) begin
      m_r = '0; m_hist.delete();
    end else if (i_load) begin
      m_r = i_ld; m_hist.delete();
    end else if (i_undo) begin
      if (m_hist.size() == 0) e.err = 1'b1;
      else m_r = ref_inv(m_r, m_hist.pop_back());
    end else if (i_op) begin
      if (m_hist.size() == DEPTH) e.err = 1'b1;
      else begin
        m_hist.push_back({i_mode, ref_lost(m_r, i_mode)});
        m_r = ref_fwd(m_r, i_mode);
      end
    end
    e.r     = m_r;
    e.level = LVL_W'(m_hist.size());
    e.full  = (m_hist.size() == DEPTH);
    e.empty = (m_hist.size() == 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0; load = 1'b0; op_valid = 1'b0; undo = 1'b0;
    got = sb.pop_front();
    n_checks += 5;
    if (r !== got.r) begin
      n_errors++; $display("FAIL %s r: got %b expected %b", got.name, r, got.r);
    end
    if (level !== got.level) begin
      n_errors++; $display("FAIL %s level: got %0d expected %0d", got.name, level, got.level);
    end
    if (full !== got.full) begin
      n_errors++; $display("FAIL %s full: got %b expected %b", got.name, full, got.full);
    end
    if (empty !== got.empty) begin
      n_errors++; $display("FAIL %s empty: got %b expected %b", got.name, empty, got.empty);
    end
    if (err !== got.err) begin
      n_errors++; $display("FAIL %s err: got %b expected %b", got.name, err, got.err);
    end
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    step("load", 1'b0, 1'b1, v, 1'b0, 3'b000, 1'b0);
  endtask
  task automatic do_op(input logic [2:0] m);
    step("op", 1'b0, 1'b0, '0, 1'b1, m, 1'b0);
  endtask
  task automatic do_undo();
    step("undo", 1'b0, 1'b0, '0, 1'b0, 3'b000, 1'b1);
  endtask
  task automatic do_idle();
    step("idle", 1'b0, 1'b0, '0, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_reset();
    step("reset", 1'b1, 1'b0, '0, 1'b0, 3'b000, 1'b0);
    step("reset", 1'b1, 1'b1, 4'b1111, 1'b1, 3'b001, 1'b1);
    n_checks++;
    if (r !== 4'b0000 || empty !== 1'b1 || full !== 1'b0 || level !== '0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got r=%b lvl=%0d e=%b f=%b err=%b expected r=0000 lvl=0 e=1 f=0 err=0",
               r, level, empty, full, err);
    end
    do_idle();
  endtask

  task automatic test_shl_undo();
    do_load(4'b1011);
    do_op(3'b000);
    n_checks++;
    if (r !== 4'b0110 || level !== LVL_W'(1)) begin
      n_errors++; $display("FAIL shl_fwd: got r=%b lvl=%0d expected r=0110 lvl=1", r, level);
    end
    do_undo();
    n_checks++;
    if (r !== 4'b1011 || level !== '0) begin
      n_errors++; $display("FAIL shl_undo: got r=%b lvl=%0d expected r=1011 lvl=0", r, level);
    end
  endtask

  task automatic test_chain();
    do_load(4'b1001);
    do_op(3'b011);
    do_op(3'b101);
    do_op(3'b110);
    n_checks++;
    if (r !== 4'b0110) begin
      n_errors++; $display("FAIL chain_fwd: got r=%b expected r=0110", r);
    end
    repeat (3) do_undo();
    n_checks++;
    if (r !== 4'b1001 || empty !== 1'b1) begin
      n_errors++; $display("FAIL chain_undo: got r=%b empty=%b expected r=1001 empty=1", r, empty);
    end
  endtask

  task automatic test_full();
    logic [WIDTH-1:0] held;
    do_load(4'b0101);
    for (int i = 0; i < DEPTH; i++) do_op(3'($urandom_range(0, 7)));
    n_checks++;
    if (full !== 1'b1 || level !== LVL_W'(DEPTH)) begin
      n_errors++; $display("FAIL full_reach: got full=%b lvl=%0d expected full=1 lvl=8", full, level);
    end
    held = r;
    do_op(3'b001);
    n_checks++;
    if (err !== 1'b1 || r !== held || level !== LVL_W'(DEPTH)) begin
      n_errors++;
      $display("FAIL full_reject: got err=%b r=%b lvl=%0d expected err=1 r=%b lvl=8", err, r, level, held);
    end
    do_idle();
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++; $display("FAIL err_pulse_width: got err=%b expected err=0", err);
    end
    repeat (DEPTH) do_undo();
    n_checks++;
    if (r !== 4'b0101) begin
      n_errors++; $display("FAIL full_roundtrip: got r=%b expected r=0101", r);
    end
  endtask

  task automatic test_conflicts();
    do_load(4'b0011);
    do_undo();
    n_checks++;
    if (err !== 1'b1 || r !== 4'b0011) begin
      n_errors++; $display("FAIL empty_undo: got err=%b r=%b expected err=1 r=0011", err, r);
    end
    do_op(3'b010);
    step("undo_op", 1'b0, 1'b0, '0, 1'b1, 3'b001, 1'b1);
    n_checks++;
    if (r !== 4'b0011 || level !== '0 || err !== 1'b0) begin
      n_errors++; $display("FAIL undo_beats_op: got r=%b lvl=%0d err=%b expected r=0011 lvl=0 err=0", r, level, err);
    end
    do_op(3'b110);
    do_op(3'b001);
    step("load_undo", 1'b0, 1'b1, 4'b1100, 1'b0, 3'b000, 1'b1);
    n_checks++;
    if (r !== 4'b1100 || level !== '0 || err !== 1'b0) begin
      n_errors++; $display("FAIL load_beats_undo: got r=%b lvl=%0d err=%b expected r=1100 lvl=0 err=0", r, level, err);
    end
  endtask

  task automatic test_rst_mid();
    do_load(4'b1010);
    do_op(3'b001);
    do_op(3'b111);
    do_op(3'b011);
    step("rst_mid", 1'b1, 1'b0, '0, 1'b1, 3'b000, 1'b0);
    n_checks++;
    if (r !== 4'b0000 || level !== '0 || empty !== 1'b1) begin
      n_errors++; $display("FAIL rst_mid: got r=%b lvl=%0d empty=%b expected r=0000 lvl=0 empty=1", r, level, empty);
    end
    do_undo();
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++; $display("FAIL rst_then_undo: got err=%b expected err=1", err);
    end
  endtask

  task automatic test_roundtrip();
    logic [WIDTH-1:0] start;
    int               k;
    for (int t = 0; t < 20; t++) begin
      start = WIDTH'($urandom);
      k     = $urandom_range(1, DEPTH);
      do_load(start);
      for (int i = 0; i < k; i++) do_op(3'($urandom_range(0, 7)));
      if (($urandom & 1) != 0) do_idle();
      for (int i = 0; i < k; i++) do_undo();
      n_checks++;
      if (r !== start) begin
        n_errors++; $display("FAIL roundtrip_%0d: got r=%b expected r=%b", t, r, start);
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_data = '0; op_valid = 1'b0; mode = '0; undo = 1'b0;
    m_r = '0;
    @(negedge clk);
    test_reset();
    test_shl_undo();
    test_chain();
    test_full();
    test_conflicts();
    test_rst_mid();
    test_roundtrip();
    if (sb.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
